jb_sysref_gate: RTL and testbench

Parametrised SYSREF conditioner/distributor in the `pl_refclk_m` domain. It samples the single-ended PL SYSREF (post-IBUFDS) and checks its period against the expected divide ratio. Once the period is stable it declares lock, then releases SYSREF to `NUM_CH` converter tiles (DAC/ADC, …) through an arm/one-shot/continuous gate with a per-channel cycle delay. It replaces fixed always-on SYSREF fan-out so tiles can be synchronised on demand.

---
 rtl/jb_sysref_gate.sv | 206 ++++++++++++++++++++
 tb/tb_jb_sysref_gate.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jb_sysref_gate.sv
// SYSREF conditioner/distributor: samples the PL SYSREF, checks its period
// against SYSREF_DIV, declares lock, and releases it to NUM_CH tiles through
// an arm/one-shot/continuous gate with a per-channel cycle delay.
module jb_sysref_gate #(
  parameter int NUM_CH     = 2,
  parameter int IN_STAGES  = 2,
  parameter int SYSREF_DIV = 128,
  parameter int CNT_W      = 9,
  parameter int LOCK_CNT   = 4,
  parameter int DLY_W      = 3
) (
  input  logic                      pl_refclk_m,
  input  logic                      rst_n,
  input  logic                      sysref_i,
  input  logic                      arm,
  input  logic                      disarm,
  input  logic                      oneshot,
  input  logic                      err_clr,
  input  logic [NUM_CH-1:0]         ch_en,
  input  logic [NUM_CH*DLY_W-1:0]   ch_dly,
  output logic [NUM_CH-1:0]         sysref_o,
  output logic                      locked,
  output logic                      period_err,
  output logic [1:0]                gate_state,
  output logic [15:0]               pulse_cnt
);

  localparam int NTAP = 2 ** DLY_W;
  localparam logic [CNT_W-1:0] PCNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] PCNT_DIV  = CNT_W'(SYSREF_DIV);
  localparam logic [3:0]       GOOD_LOCK = 4'(LOCK_CNT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2
  } gate_st_t;

  logic [IN_STAGES-1:0] sync_q;
  logic                 s_last;
  logic                 s_dly_q;
  logic                 rise;
  logic                 fall;

  logic [CNT_W-1:0]     pcnt_q, pcnt_d;
  logic                 ref_q, ref_d;
  logic [3:0]           good_q, good_d;
  logic                 locked_q, locked_d;
  logic                 err_q, err_d;
  logic                 rise_ok;
  logic                 fault;
  logic                 locked_fall;
  logic                 abort;

  gate_st_t             state_q, state_d;
  logic                 oneshot_q, oneshot_d;
  logic                 gate_open;

  logic                 g_q;
  logic [NTAP-2:0]      dly_q;
  logic [NTAP-1:0]      tap;
  logic [NUM_CH-1:0]    tap_sel;
  logic [NUM_CH-1:0]    sysref_q;
  logic [15:0]          pulse_q, pulse_d;

  // Input sampling chain plus one extra stage used for edge detection
  always_ff @(posedge pl_refclk_m or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      s_dly_q <= 1'b0;
    end else begin
      sync_q[0] <= sysref_i;
      for (int i = 1; i < IN_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      s_dly_q <= s_last;
    end
  end

  assign s_last = sync_q[IN_STAGES-1];
  assign rise   = s_last & ~s_dly_q;
  assign fall   = ~s_last & s_dly_q;

  // Period check: a rise is good only when it lands exactly SYSREF_DIV cycles
  // after the previous one; a missing edge faults when the count passes DIV.
  always_comb begin
    if (rise)                   pcnt_d = CNT_W'(1);
    else if (pcnt_q == PCNT_MAX) pcnt_d = pcnt_q;
    else                        pcnt_d = pcnt_q + CNT_W'(1);

    rise_ok = rise & ~ref_q & (pcnt_q == PCNT_DIV);
    fault   = (rise & ~ref_q & (pcnt_q != PCNT_DIV)) |
              (~rise & (pcnt_q == PCNT_DIV));

    // After a fault the next rise only re-establishes the phase reference
    ref_d = ref_q;
    if (fault)     ref_d = 1'b1;
    else if (rise) ref_d = 1'b0;

    good_d = good_q;
    if (fault)                              good_d = 4'd0;
    else if (rise_ok && good_q != GOOD_LOCK) good_d = good_q + 4'd1;

    locked_d = (good_d == GOOD_LOCK);

    // A new fault beats a simultaneous clear
    err_d = err_q;
    if (fault)        err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;

    locked_fall = locked_q & ~locked_d;
    abort       = disarm | locked_fall;
  end

  // Period-check state registers
  always_ff @(posedge pl_refclk_m or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q   <= '0;
      ref_q    <= 1'b1;
      good_q   <= 4'd0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      pcnt_q   <= pcnt_d;
      ref_q    <= ref_d;
      good_q   <= good_d;
      locked_q <= locked_d;
      err_q    <= err_d;
    end
  end

  // Gate FSM state register, with the one-shot mode captured on entry to RUN
  always_ff @(posedge pl_refclk_m or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      oneshot_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      oneshot_q <= oneshot_d;
    end
  end

  // Gate FSM next state: disarm first, then loss-of-lock abort, then normal flow
  always_comb begin
    state_d   = state_q;
    oneshot_d = oneshot_q;
    if (disarm) begin
      state_d = ST_IDLE;
    end else if (locked_fall && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (arm) state_d = ST_ARMED;
        ST_ARMED: if (rise && locked_q) begin
                    state_d   = ST_RUN;
                    oneshot_d = oneshot;
                  end
        ST_RUN:   if (oneshot_q && fall) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Gate FSM outputs: gate opens on the very rise that leaves ARMED
  always_comb begin
    gate_open = ((state_q == ST_RUN) |
                 ((state_q == ST_ARMED) & rise & locked_q)) & ~abort;
    pulse_d   = pulse_q + 16'(rise & gate_open);
  end

  // Gated level, shared delay line and released-edge counter
  always_ff @(posedge pl_refclk_m or negedge rst_n) begin
    if (!rst_n) begin
      g_q     <= 1'b0;
      dly_q   <= '0;
      pulse_q <= 16'd0;
    end else begin
      g_q     <= s_last & gate_open & ~abort;
      dly_q   <= tap[NTAP-2:0];
      pulse_q <= pulse_d;
    end
  end

  // tap[k] is the gated level delayed by k cycles
  assign tap = {dly_q, g_q};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign tap_sel[gi] = ch_en[gi] & tap[ch_dly[gi*DLY_W +: DLY_W]];
    end
  endgenerate

  // Registered per-channel outputs
  always_ff @(posedge pl_refclk_m or negedge rst_n) begin
    if (!rst_n) sysref_q <= '0;
    else        sysref_q <= tap_sel;
  end

  assign sysref_o   = sysref_q;
  assign locked     = locked_q;
  assign period_err = err_q;
  assign gate_state = state_q;
  assign pulse_cnt  = pulse_q;

endmodule

// File: tb/tb_jb_sysref_gate.sv
// Bench for jb_sysref_gate: directed phases followed by a randomized phase,
// every cycle compared with a cycle-indexed behavioural model.
module tb_jb_sysref_gate;

  localparam int NUM_CH    = 2;
  localparam int IN_STAGES = 2;
  localparam int DIV       = 128;
  localparam int CNT_W     = 9;
  localparam int LOCK      = 4;
  localparam int DLY_W     = 3;
  localparam int MAXC      = 12100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sysref_i = 1'b0;
  logic        arm = 1'b0, disarm = 1'b0, oneshot = 1'b0, err_clr = 1'b0;
  logic [1:0]  ch_en = 2'b00;
  logic [5:0]  ch_dly = 6'd0;
  logic [1:0]  sysref_o;
  logic        locked, period_err;
  logic [1:0]  gate_state;
  logic [15:0] pulse_cnt;

  always #5 clk = ~clk;

  jb_sysref_gate #(
    .NUM_CH(NUM_CH), .IN_STAGES(IN_STAGES), .SYSREF_DIV(DIV),
    .CNT_W(CNT_W), .LOCK_CNT(LOCK), .DLY_W(DLY_W)
  ) dut (
    .pl_refclk_m(clk), .rst_n(rst_n), .sysref_i(sysref_i),
    .arm(arm), .disarm(disarm), .oneshot(oneshot), .err_clr(err_clr),
    .ch_en(ch_en), .ch_dly(ch_dly), .sysref_o(sysref_o),
    .locked(locked), .period_err(period_err),
    .gate_state(gate_state), .pulse_cnt(pulse_cnt)
  );

  int n_pass = 0, n_total = 0, n_fail = 0, cyc = 0;

  // Input level per cycle and gated level per cycle (history arrays)
  bit xh [MAXC];
  bit gh [MAXC];

  // Behavioural model state (values visible in the current cycle)
  int       last_rise = 0;
  bit       need_ref = 1'b1;
  int       good = 0;
  bit       m_locked = 1'b0, m_err = 1'b0, m_os = 1'b0;
  int       m_state = 0, m_pulses = 0;
  bit [1:0] m_out = 2'b00;

  // Waveform generator
  int wcnt, wper, whi, last_hi = -1000, stuck_e = 0;
  bit stuck = 1'b0, ready = 1'b0;

  function automatic bit xs(int i);
    return (i < 0) ? 1'b0 : xh[i];
  endfunction

  function automatic bit gs(int i);
    return (i < 0) ? 1'b0 : gh[i];
  endfunction

  task automatic check(string name, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s at cycle %0d: got %0d, want %0d", name, cyc, act, exp);
    end
  endtask

  task automatic compare_all();
    check("sysref_o",   int'(sysref_o),   int'(m_out));
    check("locked",     int'(locked),     int'(m_locked));
    check("period_err", int'(period_err), int'(m_err));
    check("gate_state", int'(gate_state), m_state);
    check("pulse_cnt",  int'(pulse_cnt),  m_pulses);
  endtask

  // Advance the model from cycle c to c+1 using the inputs driven in cycle c
  task automatic model_step(int c);
    bit sl, sp, rise, fall, fault, lk_new, lfall, abrt, open;
    int per, ns, d;
    sl    = xs(c - IN_STAGES);
    sp    = xs(c - IN_STAGES - 1);
    rise  = sl & !sp;
    fall  = !sl & sp;
    fault = 1'b0;
    per   = c - last_rise;
    if (rise) begin
      if (need_ref) need_ref = 1'b0;
      else if (per == DIV) begin
        if (good < LOCK) good++;
      end else fault = 1'b1;
      last_rise = c;
    end else if (per == DIV) begin
      fault = 1'b1;
    end
    if (fault) begin
      need_ref = 1'b1;
      good     = 0;
    end
    lk_new = (good == LOCK);
    lfall  = m_locked & !lk_new;
    abrt   = disarm | lfall;
    open   = ((m_state == 2) || (m_state == 1 && rise && m_locked)) && !abrt;
    ns = m_state;
    if (disarm) ns = 0;
    else if (lfall && m_state != 0) ns = 0;
    else if (m_state == 0 && arm) ns = 1;
    else if (m_state == 1 && rise && m_locked) begin
      ns   = 2;
      m_os = oneshot;
    end else if (m_state == 2 && m_os && fall) ns = 0;
    if (rise && open) m_pulses = (m_pulses + 1) % 65536;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      d = int'(ch_dly[ch*DLY_W +: DLY_W]);
      m_out[ch] = ch_en[ch] ? gs(c - d) : 1'b0;
    end
    gh[c+1] = sl & open;
    if (fault) m_err = 1'b1;
    else if (err_clr) m_err = 1'b0;
    m_locked = lk_new;
    m_state  = ns;
  endtask

  task automatic pick_period(int c);
    whi  = 16;
    wper = DIV;
    if (c == 1920) wper = 127;
    else if (c == 2815) wper = 129;
    else if (c >= 3600 && c < 9600) begin
      whi = int'($urandom_range(40, 8));
      if ($urandom_range(9, 0) == 0) begin
        case ($urandom_range(4, 0))
          0: wper = 126;
          1: wper = 127;
          2: wper = 129;
          3: wper = 130;
          default: wper = 200;
        endcase
      end
    end
  endtask

  // Hand-derived expectations at specific cycles of the directed phases
  task automatic literal_checks(int c);
    case (c)
      0: begin
        check("reset_sysref_o", int'(sysref_o), 0);
        check("reset_locked", int'(locked), 0);
        check("reset_period_err", int'(period_err), 0);
        check("reset_gate_state", int'(gate_state), 0);
        check("reset_pulse_cnt", int'(pulse_cnt), 0);
      end
      514: check("lock_not_yet", int'(locked), 0);
      515: begin
        check("lock_after_5th_rise", int'(locked), 1);
        check("model_lock_pin", int'(m_locked), 1);
      end
      699: check("no_arm_pulse_cnt", int'(pulse_cnt), 0);
      771: check("os_state_run", int'(gate_state), 2);
      772: check("os_ch0_rise", int'(sysref_o), 1);
      779: check("os_ch1_dly7", int'(sysref_o), 3);
      786: check("os_state_before_fall", int'(gate_state), 2);
      787: begin
        check("os_idle_after_fall", int'(gate_state), 0);
        check("os_ch0_last_high", int'(sysref_o), 3);
      end
      788: check("os_ch0_low", int'(sysref_o), 2);
      795: check("os_all_low", int'(sysref_o), 0);
      900: check("os_pulse_cnt", int'(pulse_cnt), 1);
      1547: begin
        check("cont_disarm_state", int'(gate_state), 0);
        check("cont_last_high", int'(sysref_o), 1);
      end
      1548: check("cont_truncated", int'(sysref_o), 0);
      1600: check("cont_pulse_cnt", int'(pulse_cnt), 6);
      2049: begin
        check("short_locked_before", int'(locked), 1);
        check("short_run_before", int'(gate_state), 2);
      end
      2050: begin
        check("short_err_set", int'(period_err), 1);
        check("short_lock_lost", int'(locked), 0);
        check("short_run_aborted", int'(gate_state), 0);
      end
      2100: check("short_pulse_cnt", int'(pulse_cnt), 7);
      2689: check("relock_not_yet", int'(locked), 0);
      2690: check("relock", int'(locked), 1);
      2701: check("err_cleared", int'(period_err), 0);
      2945: check("miss_err_before", int'(period_err), 0);
      2946: check("clr_vs_fault_set_wins", int'(period_err), 1);
      3458: check("relock2_not_yet", int'(locked), 0);
      3459: check("relock2", int'(locked), 1);
      default: ;
    endcase
    if (stuck_e > 0 && c == stuck_e - 1) check("stuck_err_before", int'(period_err), 0);
    if (stuck_e > 0 && c == stuck_e)     check("stuck_err_at_129", int'(period_err), 1);
  endtask

  initial begin
    wper = DIV;
    whi  = 16;
    wcnt = wper;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int c = 0; c < 12000; c++) begin
      cyc = c;
      compare_all();
      literal_checks(c);
      if (c >= 11100 && m_out[0]) begin
        ready = 1'b1;
        break;
      end

      arm = 1'b0; disarm = 1'b0; err_clr = 1'b0;
      if (c == 0) begin ch_en = 2'b11; ch_dly = {3'd7, 3'd0}; end
      if (c == 700) begin arm = 1'b1; oneshot = 1'b1; end
      if (c == 1000) begin arm = 1'b1; oneshot = 1'b0; ch_en = 2'b01; end
      if (c == 1546) disarm = 1'b1;
      if (c == 1800) begin arm = 1'b1; oneshot = 1'b0; end
      if (c == 1700 || c == 2700 || c == 2945 || c == 3500 || c == 10000) err_clr = 1'b1;
      if (c >= 3600 && c < 9600) begin
        if ($urandom_range(149, 0) == 0) arm = 1'b1;
        if ($urandom_range(399, 0) == 0) disarm = 1'b1;
        if ($urandom_range(299, 0) == 0) err_clr = 1'b1;
        oneshot = 1'($urandom_range(1, 0));
        if ($urandom_range(99, 0) == 0) ch_en = 2'($urandom_range(3, 0));
        if ($urandom_range(99, 0) == 0) ch_dly = 6'($urandom);
      end
      if (c == 9600) begin disarm = 1'b1; ch_en = 2'b11; ch_dly = {3'd7, 3'd0}; end
      if (c == 10100) begin stuck = 1'b1; stuck_e = last_hi + IN_STAGES + DIV + 1; end
      if (c == 10500) begin stuck = 1'b0; wcnt = wper; end
      if (c == 11100) begin arm = 1'b1; oneshot = 1'b0; end

      if (wcnt >= wper) begin
        wcnt = 0;
        pick_period(c);
      end
      sysref_i = !stuck && (wcnt < whi);
      wcnt++;
      if (sysref_i && !xs(c - 1)) last_hi = c;
      xh[c] = sysref_i;
      model_step(c);
      @(posedge clk);
      #1;
    end

    check("reset_setup_reached", int'(ready), 1);
    if (ready) begin
      check("pre_reset_ch0_high", int'(sysref_o[0]), 1);
      #2 rst_n = 1'b0;
      #1;
      check("async_reset_sysref_o", int'(sysref_o), 0);
      check("async_reset_gate_state", int'(gate_state), 0);
      check("async_reset_locked", int'(locked), 0);
      check("async_reset_pulse_cnt", int'(pulse_cnt), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
